hazard_ctrl: RTL

Pipeline hazard controller for the 5-stage MIPS core. It tracks the destination register and result class of every instruction in E, M and W, and drives all bypass-select buses consumed by the forwarding multiplexers. It also raises the decode stall that freezes F/D and injects a bubble into E, and sequences the multiply/divide unit's busy window. It sits beside the decode stage and takes per-instruction use/produce descriptors from the main decoder.

---
 rtl/hazard_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS core: shadow E/M/W descriptors, decode stall,
// bypass-select generation and the multiply/divide busy window.
module hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [1:0] rs_use_D,
  input  logic [1:0] rt_use_D,
  input  logic       rt_store_D,
  input  logic [4:0] dst_D,
  input  logic [1:0] res_D,
  input  logic       md_start_D,
  input  logic       md_div_D,
  input  logic       md_read_D,
  output logic       stall,
  output logic [1:0] bypass_rs_b,
  output logic [1:0] bypass_rt_b,
  output logic [1:0] bypass_rs_jr,
  output logic [1:0] bypass_rt_ji,
  output logic [1:0] bypass_rs_alu,
  output logic [1:0] bypass_rt_alu,
  output logic       bypass_rt_mem,
  output logic       md_busy
);

  localparam logic [1:0] ResNone = 2'd0;
  localparam logic [1:0] ResPc8  = 2'd1;
  localparam logic [1:0] ResAlu  = 2'd2;
  localparam logic [1:0] ResLoad = 2'd3;

  localparam logic [1:0] UseBranch = 2'd1;
  localparam logic [1:0] UseAlu    = 2'd3;

  localparam logic [3:0] MultLoad = 4'(MULT_CYCLES);
  localparam logic [3:0] DivLoad  = 4'(DIV_CYCLES);

  logic [4:0] e_rs_q, e_rt_q, e_dst_q, m_rt_q, m_dst_q, w_dst_q;
  logic [1:0] e_res_q, m_res_q, w_res_q;
  logic [3:0] md_cnt_q, md_cnt_d;

  function automatic logic hit(input logic [4:0] dst, input logic [1:0] res,
                               input logic [4:0] op);
    return (dst == op) && (dst != 5'd0) && (res != ResNone);
  endfunction

  logic [1:0] tnew_e, tnew_m, tuse_rs, tuse_rt;
  logic       e_rs, e_rt, m_rs, m_rt, w_rs, w_rt;
  logic       stall_rs, stall_rt, stall_st, data_stall, busy_stall;

  always_comb begin
    unique case (e_res_q)
      ResAlu:  tnew_e = 2'd1;
      ResLoad: tnew_e = 2'd2;
      default: tnew_e = 2'd0;
    endcase
    tnew_m  = (m_res_q == ResLoad) ? 2'd1 : 2'd0;
    tuse_rs = (rs_use_D == UseAlu) ? 2'd1 : 2'd0;
    tuse_rt = (rt_use_D == UseAlu) ? 2'd1 : 2'd0;

    e_rs = hit(e_dst_q, e_res_q, rs_D);
    e_rt = hit(e_dst_q, e_res_q, rt_D);
    m_rs = hit(m_dst_q, m_res_q, rs_D);
    m_rt = hit(m_dst_q, m_res_q, rt_D);
    w_rs = hit(w_dst_q, w_res_q, rs_D);
    w_rt = hit(w_dst_q, w_res_q, rt_D);

    // Branch compares have no E bypass, so any E producer stalls them.
    stall_rs = (rs_use_D != 2'd0) &&
               ((e_rs && ((tnew_e > tuse_rs) || (rs_use_D == UseBranch))) ||
                (m_rs && (tnew_m > tuse_rs)));
    stall_rt = (rt_use_D != 2'd0) &&
               ((e_rt && ((tnew_e > tuse_rt) || (rt_use_D == UseBranch))) ||
                (m_rt && (tnew_m > tuse_rt)));
    stall_st = rt_store_D && ((e_rt && (tnew_e > 2'd2)) || (m_rt && (tnew_m > 2'd2)));

    data_stall = stall_rs || stall_rt || stall_st;
    busy_stall = (md_start_D || md_read_D) && (md_cnt_q != 4'd0);
    stall      = data_stall || busy_stall;
    md_busy    = (md_cnt_q != 4'd0);
  end

  always_comb begin
    bypass_rs_b = m_rs ? 2'd1 : (w_rs ? 2'd2 : 2'd0);
    bypass_rt_b = m_rt ? 2'd1 : (w_rt ? 2'd2 : 2'd0);

    bypass_rs_jr = (e_rs && (e_res_q == ResPc8)) ? 2'd1 :
                   m_rs ? 2'd2 : (w_rs ? 2'd3 : 2'd0);
    bypass_rt_ji = (e_rt && (e_res_q == ResPc8)) ? 2'd1 :
                   m_rt ? 2'd2 : (w_rt ? 2'd3 : 2'd0);

    bypass_rs_alu = (hit(m_dst_q, m_res_q, e_rs_q) && (m_res_q != ResLoad)) ? 2'd1 :
                    hit(w_dst_q, w_res_q, e_rs_q) ? 2'd2 : 2'd0;
    bypass_rt_alu = (hit(m_dst_q, m_res_q, e_rt_q) && (m_res_q != ResLoad)) ? 2'd1 :
                    hit(w_dst_q, w_res_q, e_rt_q) ? 2'd2 : 2'd0;

    bypass_rt_mem = hit(w_dst_q, w_res_q, m_rt_q);
  end

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_start_D && !stall) begin
      md_cnt_d = md_div_D ? DivLoad : MultLoad;
    end else if (md_cnt_q != 4'd0) begin
      md_cnt_d = md_cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_rs_q   <= '0;
      e_rt_q   <= '0;
      e_dst_q  <= '0;
      e_res_q  <= ResNone;
      m_rt_q   <= '0;
      m_dst_q  <= '0;
      m_res_q  <= ResNone;
      w_dst_q  <= '0;
      w_res_q  <= ResNone;
      md_cnt_q <= '0;
    end else begin
      if (stall) begin
        e_rs_q  <= '0;
        e_rt_q  <= '0;
        e_dst_q <= '0;
        e_res_q <= ResNone;
      end else begin
        e_rs_q  <= rs_D;
        e_rt_q  <= rt_D;
        e_dst_q <= dst_D;
        e_res_q <= res_D;
      end
      m_rt_q   <= e_rt_q;
      m_dst_q  <= e_dst_q;
      m_res_q  <= e_res_q;
      w_dst_q  <= m_dst_q;
      w_res_q  <= m_res_q;
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule
